// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: one request becomes 1..2**LEN_W word accesses.
// Latency: first SRAM cycle one clock after acceptance; each beat lasts WAIT_CYC clocks.
// Backpressure: req_ready is low for a whole burst and on its done cycle; wready paces write data.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready/req_we       request handshake and direction (1 = write)
//   req_addr, req_len, req_be        byte address, beats minus one, byte enables
//   wdata/wready                     write beat data, pulsed when the beat's data is consumed
//   rdata/rvalid                     read beat data, pulsed one clock after the beat completes
//   done, busy                       end-of-burst pulse, high while a burst is in flight
//   sram_*                           asynchronous SRAM pins (active-low strobes, shared dq)
//   err                              only with SRAM_BURST_CTRL_RANGE_CHECK_EN: out-of-range request
//
// Optional feature macro: SRAM_BURST_CTRL_RANGE_CHECK_EN. When undefined, address bits
// above the SRAM word field are ignored and there is no err port.

module sram_burst_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SRAM_AW  = 17,
    parameter int WAIT_CYC = 6,
    parameter int LEN_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [DATA_W/8-1:0]   req_be,

    input  logic [DATA_W-1:0]     wdata,
    output logic                  wready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,

    output logic                  done,
    output logic                  busy,
`ifdef SRAM_BURST_CTRL_RANGE_CHECK_EN
    output logic                  err,
`endif

    inout  wire  [DATA_W-1:0]     sram_dq,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic                  sram_we_n,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic [DATA_W/8-1:0]   sram_be_n
);

    localparam int BE_W = DATA_W / 8;
    // Byte offset bits dropped to form the SRAM word address.
    localparam int OFF  = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int WC_W = (WAIT_CYC > 2) ? $clog2(WAIT_CYC) : 1;

    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [WC_W-1:0]      wait_q, wait_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rd_done_q, rd_done_d;
    logic                 err_q, err_d;

    logic                 wait_last;
    logic                 beat_last;
    logic                 accept;
    logic                 addr_bad;
    logic                 wr_done;
    logic [SRAM_AW-1:0]   word_addr;
    logic                 unused_addr;

    // Low address bits (byte offset) and, without the range check, the
    // upper bits are deliberately not used.
    assign unused_addr = ^req_addr;

    assign word_addr = req_addr[OFF+SRAM_AW-1:OFF];

`ifdef SRAM_BURST_CTRL_RANGE_CHECK_EN
    assign addr_bad = |req_addr[ADDR_W-1:OFF+SRAM_AW];
    assign err      = err_q;
`else
    assign addr_bad = 1'b0;
`endif

    assign wait_last = (wait_q == WAIT_LAST);
    assign beat_last = (beat_q == len_q);
    assign wr_done   = (state_q == S_WRITE) && wait_last && beat_last;

    // A write burst ends inside WRITE; a read burst (and a rejected request)
    // reports done from IDLE one clock later, so ready is masked on that
    // cycle to keep at least one idle cycle between bursts.
    assign done      = wr_done || rd_done_q || err_q;
    assign req_ready = (state_q == S_IDLE) && !done;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != S_IDLE);

    assign wready    = (state_q == S_WRITE) && wait_last;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;

    // SRAM pins are pure decodes of the state so an asynchronous reset
    // releases the bus immediately.
    assign sram_addr = addr_q;
    assign sram_ce_n = (state_q == S_IDLE);
    assign sram_be_n = (state_q == S_IDLE) ? {BE_W{1'b1}} : ~be_q;
    // we_n rises on the last count so data is held past the write strobe.
    assign sram_we_n = !((state_q == S_WRITE) && !wait_last);
    assign sram_oe_n = (state_q != S_READ);
    assign sram_dq   = (state_q == S_WRITE) ? wdata : {DATA_W{1'bz}};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wait_d    = wait_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        rd_done_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = req_len;
                        be_d    = req_be;
                        addr_d  = word_addr;
                        wait_d  = '0;
                        beat_d  = '0;
                        state_d = req_we ? S_WRITE : S_READ;
                    end
                end
            end

            S_WRITE, S_READ: begin
                if (wait_last) begin
                    wait_d = '0;
                    if (state_q == S_READ) begin
                        rdata_d  = sram_dq;
                        rvalid_d = 1'b1;
                    end
                    if (beat_last) begin
                        state_d   = S_IDLE;
                        rd_done_d = (state_q == S_READ);
                    end else begin
                        beat_d = beat_q + 1'b1;
                        // Wraps naturally at the top of the SRAM.
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            be_q      <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            beat_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            beat_q    <= beat_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural SRAM on the dq bus.
// Reads return 0xA500_0000 | word address; writes are captured on each strobed clock.
// Cycle 0 of each scenario is the clock where the request is presented and accepted.

module tb_sram_burst_ctrl;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int SRAM_AW  = 17;
    localparam int WAIT_CYC = 6;
    localparam int LEN_W    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_addr;
    logic [LEN_W-1:0]     req_len;
    logic [DATA_W/8-1:0]  req_be;
    logic [DATA_W-1:0]    wdata;
    logic                 wready;
    logic [DATA_W-1:0]    rdata;
    logic                 rvalid;
    logic                 done;
    logic                 busy;
`ifdef SRAM_BURST_CTRL_RANGE_CHECK_EN
    logic                 err;
`endif
    wire  [DATA_W-1:0]    sram_dq;
    logic [SRAM_AW-1:0]   sram_addr;
    logic                 sram_we_n;
    logic                 sram_ce_n;
    logic                 sram_oe_n;
    logic [DATA_W/8-1:0]  sram_be_n;

    logic [DATA_W-1:0]    last_wr_dat;
    logic [SRAM_AW-1:0]   last_wr_addr;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SRAM_AW  (SRAM_AW),
        .WAIT_CYC (WAIT_CYC),
        .LEN_W    (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_be    (req_be),
        .wdata     (wdata),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .done      (done),
        .busy      (busy),
`ifdef SRAM_BURST_CTRL_RANGE_CHECK_EN
        .err       (err),
`endif
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_be_n (sram_be_n)
    );

    // SRAM model: drives read data while output-enabled, records writes.
    assign sram_dq = (!sram_oe_n && !sram_ce_n) ? (32'hA500_0000 | 32'(sram_addr)) : 32'bz;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            last_wr_dat  <= sram_dq;
            last_wr_addr <= sram_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next sampling point, 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_be    = '0;
        wdata     = '0;
        #12;

        // ---- reset values ----
        chk("rst_ready",  req_ready, 1'b1);
        chk("rst_busy",   busy,      1'b0);
        chk("rst_wready", wready,    1'b0);
        chk("rst_rvalid", rvalid,    1'b0);
        chk("rst_done",   done,      1'b0);
        chk("rst_rdata",  rdata,     32'h0);
        chk("rst_addr",   sram_addr, 17'h0);
        chk("rst_we_n",   sram_we_n, 1'b1);
        chk("rst_oe_n",   sram_oe_n, 1'b1);
        chk("rst_ce_n",   sram_ce_n, 1'b1);
        chk("rst_be_n",   sram_be_n, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // ---- single write, addr 0x10 ----
        wdata = 32'hDEAD_BEEF; req_we = 1'b1; req_addr = 32'h10; req_len = 3'd0;
        req_be = 4'hF; req_valid = 1'b1;
        chk("t1_accept_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_addr", sram_addr, 17'h4);
        chk("t1_ce_n", sram_ce_n, 1'b0);
        chk("t1_be_n", sram_be_n, 4'h0);
        chk("t1_oe_n", sram_oe_n, 1'b1);
        chk("t1_dq",   sram_dq,   32'hDEAD_BEEF);
        for (int c = 1; c <= 6; c++) begin
            chk("t1_we_n",   sram_we_n, c == 6);
            chk("t1_wready", wready,    c == 6);
            chk("t1_done",   done,      c == 6);
            if (c < 6) cyc();
        end
        cyc();
        chk("t1_idle_busy",  busy,         1'b0);
        chk("t1_idle_ready", req_ready,    1'b1);
        chk("t1_idle_ce_n",  sram_ce_n,    1'b1);
        chk("t1_idle_be_n",  sram_be_n,    4'hF);
        chk("t1_wr_dat",     last_wr_dat,  32'hDEAD_BEEF);
        chk("t1_wr_addr",    last_wr_addr, 17'h4);
        cyc();

        // ---- 4-beat read, addr 0x100 ----
        req_we = 1'b0; req_addr = 32'h100; req_len = 3'd3; req_valid = 1'b1;
        chk("t2_accept_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        chk("t2_oe_n", sram_oe_n, 1'b0);
        chk("t2_we_n", sram_we_n, 1'b1);
        for (int c = 1; c <= 25; c++) begin
            if (c <= 24) chk("t2_addr", sram_addr, 17'h40 + 17'((c - 1) / 6));
            chk("t2_rvalid", rvalid, (c >= 7) && ((c - 7) % 6 == 0));
            if ((c >= 7) && ((c - 7) % 6 == 0))
                chk("t2_rdata", rdata, 32'hA500_0040 + 32'((c - 7) / 6));
            chk("t2_done", done, c == 25);
            if (c < 25) cyc();
        end
        chk("t2_end_busy",  busy,      1'b0);
        chk("t2_end_ready", req_ready, 1'b0);
        cyc();
        chk("t2_after_ready",  req_ready, 1'b1);
        chk("t2_after_rvalid", rvalid,    1'b0);

        // ---- address wrap, 2-beat read at the top word ----
        req_we = 1'b0; req_addr = 32'h7FFFC; req_len = 3'd1; req_valid = 1'b1;
        chk("t3_accept_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        chk("t3_addr0", sram_addr, 17'h1FFFF);
        cycn(6);
        chk("t3_addr1",   sram_addr, 17'h00000);
        chk("t3_rvalid0", rvalid,    1'b1);
        chk("t3_rdata0",  rdata,     32'hA501_FFFF);
        chk("t3_done0",   done,      1'b0);
        cycn(6);
        chk("t3_rvalid1", rvalid, 1'b1);
        chk("t3_rdata1",  rdata,  32'hA500_0000);
        chk("t3_done1",   done,   1'b1);
        cyc();

        // ---- back-to-back writes with req_valid held high ----
        wdata = 32'h1234_5678; req_we = 1'b1; req_addr = 32'h20; req_len = 3'd1;
        req_be = 4'hF; req_valid = 1'b1;
        chk("t4_accept_ready", req_ready, 1'b1);
        cyc();
        req_addr = 32'h40; req_len = 3'd0;
        for (int c = 1; c <= 12; c++) begin
            chk("t4_ready_mid", req_ready, 1'b0);
            chk("t4_addr",      sram_addr, 17'h8 + 17'((c - 1) / 6));
            chk("t4_done",      done,      c == 12);
            cyc();
        end
        chk("t4_gap_ready", req_ready, 1'b1);
        chk("t4_gap_busy",  busy,      1'b0);
        cyc();
        req_valid = 1'b0;
        chk("t4_second_busy", busy,      1'b1);
        chk("t4_second_addr", sram_addr, 17'h10);
        cycn(5);
        chk("t4_second_done", done, 1'b1);
        cyc();
        chk("t4_end_busy", busy,         1'b0);
        chk("t4_wr_addr",  last_wr_addr, 17'h10);

        // ---- reset during beat 2 of a 4-beat write ----
        wdata = 32'hCAFE_F00D; req_we = 1'b1; req_addr = 32'h200; req_len = 3'd3;
        req_be = 4'hF; req_valid = 1'b1;
        chk("t5_accept_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        cycn(8);
        chk("t5_mid_we_n", sram_we_n, 1'b0);
        chk("t5_mid_addr", sram_addr, 17'h81);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_we_n",  sram_we_n, 1'b1);
        chk("t5_rst_ce_n",  sram_ce_n, 1'b1);
        chk("t5_rst_oe_n",  sram_oe_n, 1'b1);
        chk("t5_rst_be_n",  sram_be_n, 4'hF);
        chk("t5_rst_busy",  busy,      1'b0);
        chk("t5_rst_done",  done,      1'b0);
        chk("t5_rst_addr",  sram_addr, 17'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            chk("t5_no_done", done, 1'b0);
            chk("t5_idle",    busy, 1'b0);
            cyc();
        end
        chk("t5_ready", req_ready, 1'b1);

        // ---- address with bits above the SRAM field ----
        wdata = 32'h0BAD_0BAD; req_we = 1'b1; req_addr = 32'h0080_0000; req_len = 3'd0;
        req_be = 4'h3; req_valid = 1'b1;
        chk("t6_accept_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
`ifdef SRAM_BURST_CTRL_RANGE_CHECK_EN
        chk("t6_err",  err,       1'b1);
        chk("t6_done", done,      1'b1);
        chk("t6_busy", busy,      1'b0);
        chk("t6_ce_n", sram_ce_n, 1'b1);
        cyc();
        chk("t6_err_clr", err,       1'b0);
        chk("t6_ce_n2",   sram_ce_n, 1'b1);
        chk("t6_ready",   req_ready, 1'b1);
`else
        chk("t6_busy", busy,      1'b1);
        chk("t6_ce_n", sram_ce_n, 1'b0);
        chk("t6_addr", sram_addr, 17'h0);
        chk("t6_be_n", sram_be_n, 4'hC);
        cycn(5);
        chk("t6_done", done, 1'b1);
        cyc();
        chk("t6_wr_dat", last_wr_dat, 32'h0BAD_0BAD);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
